alu_unit: RTL

- Next-generation integer execution unit for the Tomasulo core.
- Sits between the ALU reservation station and the CDB arbiter.
- Adds a parametrised issue queue, a registered CDB result held under a grant handshake, and a pipeline flush on misprediction.
- Adds an optional iterative RV32M multiplier path alongside the single-cycle integer ops.

---
 rtl/alu_unit_if.sv | 33 +++
 rtl/alu_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_unit_if.sv
// Bundles the reservation-station issue port and the CDB result port of alu_unit.
// slave is the execution unit's view; master is the RS / CDB-arbiter side.
interface alu_unit_if #(
  parameter int XLEN = 32,
  parameter int ID_W = 4,
  parameter int OP_W = 6
);
  logic            in_valid_i;
  logic            in_ready_o;
  logic [OP_W-1:0] opcode_i;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] pc_i;
  logic [XLEN-1:0] r1_i;
  logic [XLEN-1:0] r2_i;
  logic [ID_W-1:0] id_i;

  logic            cdb_valid_o;
  logic            cdb_grant_i;
  logic [ID_W-1:0] cdb_id_o;
  logic [XLEN-1:0] cdb_data_o;
  logic [XLEN-1:0] cdb_pc_o;
  logic            cdb_cond_o;

  modport slave (
    input  in_valid_i, opcode_i, imm_i, pc_i, r1_i, r2_i, id_i, cdb_grant_i,
    output in_ready_o, cdb_valid_o, cdb_id_o, cdb_data_o, cdb_pc_o, cdb_cond_o
  );

  modport master (
    output in_valid_i, opcode_i, imm_i, pc_i, r1_i, r2_i, id_i, cdb_grant_i,
    input  in_ready_o, cdb_valid_o, cdb_id_o, cdb_data_o, cdb_pc_o, cdb_cond_o
  );
endinterface

// File: rtl/alu_unit.sv
// Integer execution unit: in-order issue queue, single-cycle RV32I ops, iterative
// RV32M multiplier, and a registered CDB result held until the arbiter grants it.
module alu_unit #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 4,
  parameter int ID_W     = 4,
  parameter int ENABLE_M = 1,
  parameter int OP_W     = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  input  logic       flush_i,
  alu_unit_if.slave  bus,
  output logic       busy_o
);
  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = PW + 1;
  localparam int SH   = $clog2(XLEN);
  localparam int MCW  = $clog2(XLEN);
  localparam logic [MCW-1:0] MUL_LAST = MCW'(XLEN - 2);

  localparam logic [OP_W-1:0] OP_LUI = 1,  OP_AUIPC = 2, OP_JAL = 3,  OP_JALR = 4;
  localparam logic [OP_W-1:0] OP_BEQ = 5,  OP_BNE = 6,   OP_BLT = 7,  OP_BGE = 8;
  localparam logic [OP_W-1:0] OP_BLTU = 9, OP_BGEU = 10;
  localparam logic [OP_W-1:0] OP_ADDI = 19, OP_SLTI = 20, OP_SLTIU = 21, OP_XORI = 22;
  localparam logic [OP_W-1:0] OP_ORI = 23,  OP_ANDI = 24, OP_SLLI = 25,  OP_SRLI = 26;
  localparam logic [OP_W-1:0] OP_SRAI = 27, OP_ADD = 28,  OP_SUB = 29,   OP_SLL = 30;
  localparam logic [OP_W-1:0] OP_SLT = 31,  OP_SLTU = 32, OP_XOR = 33,   OP_SRL = 34;
  localparam logic [OP_W-1:0] OP_SRA = 35,  OP_OR = 36,   OP_AND = 37;
  localparam logic [OP_W-1:0] OP_MUL = 38,  OP_MULH = 39, OP_MULHSU = 40, OP_MULHU = 41;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  state_t state, state_n;

  logic [OP_W-1:0] q_op  [DEPTH];
  logic [XLEN-1:0] q_imm [DEPTH];
  logic [XLEN-1:0] q_pc  [DEPTH];
  logic [XLEN-1:0] q_r1  [DEPTH];
  logic [XLEN-1:0] q_r2  [DEPTH];
  logic [ID_W-1:0] q_id  [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CNTW-1:0] count;

  logic            out_valid, out_cond;
  logic [ID_W-1:0] out_id;
  logic [XLEN-1:0] out_data, out_pc;

  logic [2*XLEN-1:0] m_acc, m_cand;
  logic [XLEN-1:0]   m_plier;
  logic [MCW-1:0]    m_cnt;
  logic              m_neg, m_high;
  logic [ID_W-1:0]   m_id;

  logic [OP_W-1:0] h_op;
  logic [XLEN-1:0] h_imm, h_pc, h_r1, h_r2;
  logic [ID_W-1:0] h_id;
  logic            in_ready, push, pop, out_free, head_is_mul;
  logic            mul_start, load_alu, load_mul;
  logic [XLEN-1:0] alu_data, alu_pc;
  logic            alu_cond;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [2*XLEN-1:0] mul_prod;
  logic [XLEN-1:0]   mul_result;

  assign h_op  = q_op[rd_ptr];
  assign h_imm = q_imm[rd_ptr];
  assign h_pc  = q_pc[rd_ptr];
  assign h_r1  = q_r1[rd_ptr];
  assign h_r2  = q_r2[rd_ptr];
  assign h_id  = q_id[rd_ptr];

  assign in_ready = (count < CNTW'(DEPTH));
  assign push     = bus.in_valid_i & in_ready;
  assign out_free = !out_valid | bus.cdb_grant_i;
  assign head_is_mul = (ENABLE_M != 0) &&
                       (h_op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU});

  assign bus.in_ready_o  = in_ready;
  assign bus.cdb_valid_o = out_valid;
  assign bus.cdb_id_o    = out_id;
  assign bus.cdb_data_o  = out_data;
  assign bus.cdb_pc_o    = out_pc;
  assign bus.cdb_cond_o  = out_cond;
  assign busy_o = (count != '0) | (state != IDLE) | out_valid;

  always_comb begin
    alu_data = '0;
    alu_pc   = '0;
    alu_cond = 1'b0;
    case (h_op)
      OP_LUI:    alu_data = h_imm;
      OP_AUIPC:  alu_data = h_pc + h_imm;
      OP_JAL:    begin alu_data = h_pc + XLEN'(4); alu_pc = h_pc + h_imm; alu_cond = 1'b1; end
      OP_JALR:   begin alu_data = h_pc + XLEN'(4); alu_pc = (h_r1 + h_imm) & ~XLEN'(1); alu_cond = 1'b1; end
      OP_BEQ:    begin alu_pc = h_pc + h_imm; alu_cond = (h_r1 == h_r2); end
      OP_BNE:    begin alu_pc = h_pc + h_imm; alu_cond = (h_r1 != h_r2); end
      OP_BLT:    begin alu_pc = h_pc + h_imm; alu_cond = ($signed(h_r1) < $signed(h_r2)); end
      OP_BGE:    begin alu_pc = h_pc + h_imm; alu_cond = ($signed(h_r1) >= $signed(h_r2)); end
      OP_BLTU:   begin alu_pc = h_pc + h_imm; alu_cond = (h_r1 < h_r2); end
      OP_BGEU:   begin alu_pc = h_pc + h_imm; alu_cond = (h_r1 >= h_r2); end
      OP_ADDI:   alu_data = h_r1 + h_imm;
      OP_SLTI:   alu_data = {{(XLEN-1){1'b0}}, ($signed(h_r1) < $signed(h_imm))};
      OP_SLTIU:  alu_data = {{(XLEN-1){1'b0}}, (h_r1 < h_imm)};
      OP_XORI:   alu_data = h_r1 ^ h_imm;
      OP_ORI:    alu_data = h_r1 | h_imm;
      OP_ANDI:   alu_data = h_r1 & h_imm;
      OP_SLLI:   alu_data = h_r1 << h_imm[SH-1:0];
      OP_SRLI:   alu_data = h_r1 >> h_imm[SH-1:0];
      OP_SRAI:   alu_data = $signed(h_r1) >>> h_imm[SH-1:0];
      OP_ADD:    alu_data = h_r1 + h_r2;
      OP_SUB:    alu_data = h_r1 - h_r2;
      OP_SLL:    alu_data = h_r1 << h_r2[SH-1:0];
      OP_SLT:    alu_data = {{(XLEN-1){1'b0}}, ($signed(h_r1) < $signed(h_r2))};
      OP_SLTU:   alu_data = {{(XLEN-1){1'b0}}, (h_r1 < h_r2)};
      OP_XOR:    alu_data = h_r1 ^ h_r2;
      OP_SRL:    alu_data = h_r1 >> h_r2[SH-1:0];
      OP_SRA:    alu_data = $signed(h_r1) >>> h_r2[SH-1:0];
      OP_OR:     alu_data = h_r1 | h_r2;
      OP_AND:    alu_data = h_r1 & h_r2;
      default:   alu_data = '0;
    endcase
  end

  // Multiply on magnitudes and negate the full product afterwards when exactly one operand was negative.
  always_comb begin
    a_neg = (h_op inside {OP_MUL, OP_MULH, OP_MULHSU}) && h_r1[XLEN-1];
    b_neg = (h_op inside {OP_MUL, OP_MULH}) && h_r2[XLEN-1];
    a_mag = a_neg ? -h_r1 : h_r1;
    b_mag = b_neg ? -h_r2 : h_r2;
  end

  assign mul_prod   = m_neg ? -m_acc : m_acc;
  assign mul_result = m_high ? mul_prod[2*XLEN-1:XLEN] : mul_prod[XLEN-1:0];

  always_comb begin
    state_n   = state;
    pop       = 1'b0;
    mul_start = 1'b0;
    load_alu  = 1'b0;
    load_mul  = 1'b0;
    case (state)
      IDLE: if (count != '0 && out_free) begin
        pop = 1'b1;
        if (head_is_mul) begin
          mul_start = 1'b1;
          state_n   = MUL;
        end else begin
          load_alu = 1'b1;
        end
      end
      MUL:  if (m_cnt == MUL_LAST) state_n = DONE;
      DONE: if (out_free) begin
        load_mul = 1'b1;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)              state <= IDLE;
    else if (rdy) begin
      if (flush_i)        state <= IDLE;
      else                state <= state_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_id    <= '0;
      out_data  <= '0;
      out_pc    <= '0;
      out_cond  <= 1'b0;
    end else if (rdy) begin
      if (flush_i) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        count     <= '0;
        out_valid <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        count <= count + CNTW'(push) - CNTW'(pop);
        if (load_alu) begin
          out_valid <= 1'b1;
          out_id    <= h_id;
          out_data  <= alu_data;
          out_pc    <= alu_pc;
          out_cond  <= alu_cond;
        end else if (load_mul) begin
          out_valid <= 1'b1;
          out_id    <= m_id;
          out_data  <= mul_result;
          out_pc    <= '0;
          out_cond  <= 1'b0;
        end else if (bus.cdb_grant_i) begin
          out_valid <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && rdy && !flush_i && push) begin
      q_op[wr_ptr]  <= bus.opcode_i;
      q_imm[wr_ptr] <= bus.imm_i;
      q_pc[wr_ptr]  <= bus.pc_i;
      q_r1[wr_ptr]  <= bus.r1_i;
      q_r2[wr_ptr]  <= bus.r2_i;
      q_id[wr_ptr]  <= bus.id_i;
    end
  end

  // The pop edge already applies multiplier bit 0, so MUL needs only XLEN-1 more steps.
  always_ff @(posedge clk) begin
    if (!rst && rdy && !flush_i) begin
      if (mul_start) begin
        m_acc   <= b_mag[0] ? {{XLEN{1'b0}}, a_mag} : '0;
        m_cand  <= {{(XLEN-1){1'b0}}, a_mag, 1'b0};
        m_plier <= b_mag >> 1;
        m_cnt   <= '0;
        m_neg   <= a_neg ^ b_neg;
        m_high  <= (h_op != OP_MUL);
        m_id    <= h_id;
      end else if (state == MUL) begin
        m_acc   <= m_acc + (m_plier[0] ? m_cand : '0);
        m_cand  <= m_cand << 1;
        m_plier <= m_plier >> 1;
        m_cnt   <= m_cnt + MCW'(1);
      end
    end
  end
endmodule
